// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer pointer and allocation controller.
// Owns the circular head/tail pointers, hands out up to two ROB ids per cycle,
// retires up to two entries per cycle and recovers the ROB on a full flush.
// Pointers carry one extra wrap bit so that full and empty are distinguishable.
module rob_alloc_ctrl #(
   parameter int unsigned ROB_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 alloc0_valid,
   input  logic                 alloc1_valid,
   output logic [ROB_WIDTH:0]   alloc0_robid,
   output logic [ROB_WIDTH:0]   alloc1_robid,
   output logic [1:0]           rob_left,
   input  logic                 commit0_valid,
   input  logic                 commit1_valid,
   input  logic                 flush_valid,
   output logic [ROB_WIDTH:0]   head_robid,
   output logic [ROB_WIDTH:0]   tail_robid,
   output logic [ROB_WIDTH:0]   free_count,
   output logic                 rob_empty,
   output logic                 rob_full,
   output logic                 alloc_err,
   output logic                 commit_err
);

   localparam int unsigned     DEPTH     = 2 ** ROB_WIDTH;
   localparam logic [ROB_WIDTH:0] DEPTH_CNT = (ROB_WIDTH + 1)'(DEPTH);
   localparam logic [ROB_WIDTH:0] LEFT_SAT  = (ROB_WIDTH + 1)'(3);

   // Registered state
   logic [ROB_WIDTH:0] head_q, head_d;
   logic [ROB_WIDTH:0] tail_q, tail_d;
   logic               alloc_err_q, alloc_err_d;
   logic               commit_err_q, commit_err_d;

   // Derived occupancy and request decode
   logic [ROB_WIDTH:0] occupancy;
   logic [ROB_WIDTH:0] n_alloc;
   logic [ROB_WIDTH:0] n_commit;
   logic               alloc_ok;
   logic               commit_form_ok;
   logic               commit_ok;
   logic [ROB_WIDTH:0] head_commit;

   // Occupancy, free space and status flags come only from registered pointers,
   // so commits in this cycle never free space for allocations in this cycle.
   always_comb begin
      occupancy  = tail_q - head_q;
      free_count = DEPTH_CNT - occupancy;
      rob_empty  = (head_q == tail_q);
      rob_full   = (head_q[ROB_WIDTH-1:0] == tail_q[ROB_WIDTH-1:0]) &&
                   (head_q[ROB_WIDTH] != tail_q[ROB_WIDTH]);
      rob_left   = (free_count >= LEFT_SAT) ? 2'd3 : free_count[1:0];
   end

   // Compacted id hand-out: slot 1 takes the first id when slot 0 is idle.
   always_comb begin
      alloc0_robid = tail_q;
      alloc1_robid = alloc0_valid ? (tail_q + 1'b1) : tail_q;
      head_robid   = head_q;
      tail_robid   = tail_q;
   end

   // Request legality checks for allocation and commit.
   always_comb begin
      n_alloc        = (ROB_WIDTH + 1)'(alloc0_valid) + (ROB_WIDTH + 1)'(alloc1_valid);
      n_commit       = (ROB_WIDTH + 1)'(commit0_valid) + (ROB_WIDTH + 1)'(commit1_valid);
      alloc_ok       = (n_alloc <= free_count);
      // Commit retires in order from head: slot 1 alone would skip the oldest.
      commit_form_ok = commit0_valid || !commit1_valid;
      commit_ok      = commit_form_ok && (n_commit <= occupancy);
      head_commit    = commit_ok ? (head_q + n_commit) : head_q;
   end

   // Next-state: commits always apply; flush collapses tail onto the new head
   // and discards any same-cycle allocation without flagging it.
   always_comb begin
      head_d       = head_commit;
      tail_d       = tail_q;
      alloc_err_d  = alloc_err_q;
      commit_err_d = commit_err_q;

      if (!commit_ok) begin
         commit_err_d = 1'b1;
      end

      if (flush_valid) begin
         tail_d = head_commit;
      end else if (alloc_ok) begin
         tail_d = tail_q + n_alloc;
      end else begin
         alloc_err_d = 1'b1;
      end
   end

   // State register with synchronous reset overriding all requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q       <= '0;
         tail_q       <= '0;
         alloc_err_q  <= 1'b0;
         commit_err_q <= 1'b0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         alloc_err_q  <= alloc_err_d;
         commit_err_q <= commit_err_d;
      end
   end

   // Sticky error outputs
   always_comb begin
      alloc_err  = alloc_err_q;
      commit_err = commit_err_q;
   end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed self-checking bench for rob_alloc_ctrl with hand-computed expectations.
module tb_rob_alloc_ctrl;

   logic       clk;
   logic       reset;
   logic       alloc0_valid, alloc1_valid;
   logic [4:0] alloc0_robid, alloc1_robid;
   logic [1:0] rob_left;
   logic       commit0_valid, commit1_valid, flush_valid;
   logic [4:0] head_robid, tail_robid, free_count;
   logic       rob_empty, rob_full, alloc_err, commit_err;

   int n_cmp;
   int n_err;

   rob_alloc_ctrl #(.ROB_WIDTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .alloc0_valid  (alloc0_valid),
      .alloc1_valid  (alloc1_valid),
      .alloc0_robid  (alloc0_robid),
      .alloc1_robid  (alloc1_robid),
      .rob_left      (rob_left),
      .commit0_valid (commit0_valid),
      .commit1_valid (commit1_valid),
      .flush_valid   (flush_valid),
      .head_robid    (head_robid),
      .tail_robid    (tail_robid),
      .free_count    (free_count),
      .rob_empty     (rob_empty),
      .rob_full      (rob_full),
      .alloc_err     (alloc_err),
      .commit_err    (commit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge, then let outputs settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic a0, input logic a1, input logic c0, input logic c1,
                        input logic fl);
      alloc0_valid  = a0;
      alloc1_valid  = a1;
      commit0_valid = c0;
      commit1_valid = c1;
      flush_valid   = fl;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      drive(0, 0, 0, 0, 0);
      do_reset();

      // Reset state
      check_val("rst_head", head_robid, 0);
      check_val("rst_tail", tail_robid, 0);
      check_val("rst_free", free_count, 16);
      check_val("rst_left", rob_left, 3);
      check_val("rst_empty", rob_empty, 1);
      check_val("rst_full", rob_full, 0);
      check_val("rst_aerr", alloc_err, 0);
      check_val("rst_cerr", commit_err, 0);

      // Eight dual allocations fill the ROB with ids 0..15
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, 0, 0, 0);
         check_val("fill_id0", alloc0_robid, 2 * i);
         check_val("fill_id1", alloc1_robid, 2 * i + 1);
         step();
      end
      drive(0, 0, 0, 0, 0);
      check_val("full_flag", rob_full, 1);
      check_val("full_free", free_count, 0);
      check_val("full_left", rob_left, 0);
      check_val("full_tail", tail_robid, 16);
      check_val("full_empty", rob_empty, 0);
      check_val("full_aerr", alloc_err, 0);

      // Commits do not free space for same-cycle allocation
      drive(1, 1, 1, 1, 0);
      step();
      drive(0, 0, 0, 0, 0);
      check_val("rej_aerr", alloc_err, 1);
      check_val("rej_head", head_robid, 2);
      check_val("rej_tail", tail_robid, 16);
      check_val("rej_free", free_count, 2);
      check_val("rej_left", rob_left, 2);

      // Reset clears alloc_err and overrides a same-cycle allocation
      alloc0_valid = 1'b1;
      alloc1_valid = 1'b1;
      do_reset();
      drive(0, 0, 0, 0, 0);
      check_val("rst2_aerr", alloc_err, 0);
      check_val("rst2_tail", tail_robid, 0);

      // Bring tail to 14
      for (int i = 0; i < 7; i++) begin
         drive(1, 1, 0, 0, 0);
         step();
      end
      drive(0, 0, 0, 0, 0);
      check_val("t14_tail", tail_robid, 14);
      check_val("t14_left", rob_left, 2);

      // Slot 1 alone takes the first id; dual commit in the same cycle
      drive(0, 1, 1, 1, 0);
      check_val("cmp_id1", alloc1_robid, 14);
      step();
      drive(0, 0, 0, 0, 0);
      check_val("cmp_tail", tail_robid, 15);
      check_val("cmp_head", head_robid, 2);
      check_val("cmp_free", free_count, 3);

      // Dual allocation across the wrap
      drive(1, 1, 0, 0, 0);
      check_val("wrap_id0", alloc0_robid, 15);
      check_val("wrap_id1", alloc1_robid, 16);
      step();
      drive(0, 0, 0, 0, 0);
      check_val("wrap_tail", tail_robid, 17);
      check_val("wrap_free", free_count, 1);
      check_val("wrap_left", rob_left, 1);
      check_val("wrap_aerr", alloc_err, 0);

      // Retire down to occupancy 5
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 1, 1, 0);
         step();
      end
      drive(0, 0, 0, 0, 0);
      check_val("occ5_head", head_robid, 12);
      check_val("occ5_free", free_count, 11);

      // Commit plus flush; allocations in the flush cycle are dropped silently
      drive(1, 1, 1, 0, 1);
      step();
      drive(0, 0, 0, 0, 0);
      check_val("fl_head", head_robid, 13);
      check_val("fl_tail", tail_robid, 13);
      check_val("fl_empty", rob_empty, 1);
      check_val("fl_free", free_count, 16);
      check_val("fl_aerr", alloc_err, 0);
      check_val("fl_cerr", commit_err, 0);

      // commit1 alone is illegal
      drive(1, 0, 0, 1, 0);
      step();
      drive(0, 0, 0, 0, 0);
      check_val("c1_cerr", commit_err, 1);
      check_val("c1_head", head_robid, 13);
      check_val("c1_tail", tail_robid, 14);

      do_reset();
      check_val("rst3_cerr", commit_err, 0);

      // Commit with empty ROB is illegal
      drive(0, 0, 1, 0, 0);
      step();
      drive(0, 0, 0, 0, 0);
      check_val("emp_cerr", commit_err, 1);
      check_val("emp_head", head_robid, 0);

      // Dual commit exceeding occupancy 1 is illegal and retires nothing
      do_reset();
      drive(1, 0, 0, 0, 0);
      step();
      drive(0, 0, 1, 1, 0);
      step();
      drive(0, 0, 0, 0, 0);
      check_val("ovc_cerr", commit_err, 1);
      check_val("ovc_head", head_robid, 0);
      check_val("ovc_free", free_count, 15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rob_alloc_ctrl.md
Name: rob_alloc_ctrl

Overview:
Reorder-buffer pointer and allocation controller.
- Keeps the circular head (oldest) and tail (next free) pointers of the ROB.
- Hands out up to two ROB ids per cycle to dispatch, retires up to two entries per cycle at commit.
- Publishes the saturated free-space count that dispatch uses for its can-dispatch decision.
- Sits between dispatch, the ROB storage array and the commit stage; owns all ROB occupancy state and flush recovery.

Parameters:
ROB_WIDTH, 4, log2 of ROB depth (DEPTH = 2**ROB_WIDTH = 16); ROB ids are ROB_WIDTH+1 bits, the MSB being the wrap bit.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous active-high reset
alloc0_valid  input  1  dispatch slot 0 allocates an entry this cycle
alloc1_valid  input  1  dispatch slot 1 allocates an entry this cycle
alloc0_robid  output  ROB_WIDTH+1  id for slot 0, combinational
alloc1_robid  output  ROB_WIDTH+1  id for slot 1, combinational
rob_left  output  2  min(free_count, 3), registered-state based
commit0_valid  input  1  retire oldest entry
commit1_valid  input  1  retire second-oldest entry
flush_valid  input  1  full pipeline flush
head_robid  output  ROB_WIDTH+1  oldest live entry id
tail_robid  output  ROB_WIDTH+1  next id to allocate
free_count  output  ROB_WIDTH+1  free entries, 0..DEPTH
rob_empty  output  1  free_count == DEPTH
rob_full  output  1  free_count == 0
alloc_err  output  1  sticky: over-allocation request seen
commit_err  output  1  sticky: illegal commit request seen

Behaviour:
Pointer arithmetic and derived outputs
- head and tail are ROB_WIDTH+1-bit registers; increments wrap modulo 2**(ROB_WIDTH+1).
- occupancy = tail - head, modulo 2**(ROB_WIDTH+1).
- free_count = DEPTH - occupancy.
- rob_full: low ROB_WIDTH bits equal and wrap bits differ. rob_empty: head == tail.
- rob_left, free_count, rob_full and rob_empty derive only from registered head/tail. Commits in cycle N do not create space visible to allocations in cycle N.

Reset
- head = tail = 0, free_count = DEPTH, rob_left = 3, rob_empty = 1, rob_full = 0, alloc_err = commit_err = 0.
- Reset overrides flush, alloc and commit in the same cycle.

Allocation
- n_alloc = alloc0_valid + alloc1_valid.
- alloc0_robid = tail.
- alloc1_robid = alloc0_valid ? tail+1 : tail (compacted).
- If n_alloc <= free_count: tail += n_alloc at the next edge.
- Otherwise: no allocation this cycle, alloc_err set (sticky until reset).
- With dispatch honouring rob_left, the error path must never fire.

Commit
- Commit is in order from head. Legal forms: commit0 only, or commit0 together with commit1.
- commit1_valid without commit0_valid is illegal: commit_err set, nothing retired.
- n_commit > occupancy is illegal: commit_err set, nothing retired.
- Legal commit: head += n_commit.

Flush
- Commits in the flush cycle still apply: head_next = head + n_commit.
- tail_next = head_next, so the ROB is empty the next cycle.
- Allocations in the flush cycle are ignored, with no alloc_err.

Other timing rules
- Simultaneous legal alloc and commit update both pointers independently in one cycle.
- Latency: allocated ids are visible on tail_robid and free_count one cycle after the alloc edge.

Test Plan:
- Reset -> head = tail = 0, free_count = 16, rob_left = 3, rob_empty = 1, rob_full = 0.
- Eight cycles of dual alloc, no commit -> ids 0..15 issued in order; then rob_full = 1, free_count = 0, rob_left = 0, tail_robid = 5'b10000.
- From full, dual commit plus dual alloc in the same cycle -> alloc rejected, alloc_err = 1, head = 2; next cycle free_count = 2, rob_left = 2.
- Tail at 14: alloc1_valid only -> alloc1_robid = 14. Next cycle dual alloc -> ids 15 and 16 (wrap bit set); tail_robid = 17.
- Occupancy 5, commit0 + flush in the same cycle -> next cycle head = tail = old head + 1, rob_empty = 1, free_count = 16.
- commit1_valid alone, or commit0 with occupancy 0 -> commit_err = 1, head unchanged; reset clears commit_err.
